// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch stalls, data-memory wait freeze with timeout trap, and stall counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_rsD,
  input  logic [4:0]       i_rtD,
  input  logic [4:0]       i_rsE,
  input  logic [4:0]       i_rtE,
  input  logic             i_BranchD,
  input  logic             i_PCSrcD,
  input  logic [4:0]       i_WriteregE,
  input  logic             i_RegwriteE,
  input  logic             i_MemtoregE,
  input  logic [4:0]       i_WriteregM,
  input  logic             i_RegwriteM,
  input  logic             i_MemtoregM,
  input  logic             i_MemwriteM,
  input  logic             i_dmem_ready,
  input  logic [4:0]       i_WriteregW,
  input  logic             i_RegwriteW,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_StallE,
  output logic             o_StallM,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_FlushW,
  output logic             o_ForwardAD,
  output logic             o_ForwardBD,
  output logic [1:0]       o_ForwardAE,
  output logic [1:0]       o_ForwardBE,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_lw_stall_cnt,
  output logic [CNT_W-1:0] o_mem_stall_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

  state_t           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_lw_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  logic w_lwstall;
  logic w_brstall;
  logic w_hazard;
  logic w_memstall;
  logic w_in_err;
  logic w_lw_count;
  logic w_mem_count;

  assign w_lwstall  = i_MemtoregE && ((i_rtE == i_rsD) || (i_rtE == i_rtD));
  assign w_brstall  = i_BranchD &&
                      ((i_RegwriteE && (i_WriteregE != 5'd0) &&
                        ((i_WriteregE == i_rsD) || (i_WriteregE == i_rtD))) ||
                       (i_MemtoregM && (i_WriteregM != 5'd0) &&
                        ((i_WriteregM == i_rsD) || (i_WriteregM == i_rtD))));
  assign w_hazard   = w_lwstall || w_brstall;
  assign w_memstall = (i_MemtoregM || i_MemwriteM) && !i_dmem_ready;
  assign w_in_err   = (r_state == ERR);

  // Memory freeze (or the error trap) dominates; a load-use/branch stall hides a taken PCSrcD.
  assign o_StallF = w_in_err || w_memstall || w_hazard;
  assign o_StallD = w_in_err || w_memstall || w_hazard;
  assign o_StallE = w_in_err || w_memstall;
  assign o_StallM = w_in_err || w_memstall;
  assign o_FlushW = w_in_err || w_memstall;
  assign o_FlushE = !w_in_err && !w_memstall && w_hazard;
  assign o_FlushD = !w_in_err && !w_memstall && !w_hazard && i_PCSrcD;

  assign o_ForwardAD = (i_rsD != 5'd0) && i_RegwriteM && (i_rsD == i_WriteregM);
  assign o_ForwardBD = (i_rtD != 5'd0) && i_RegwriteM && (i_rtD == i_WriteregM);

  always_comb begin
    o_ForwardAE = 2'b00;
    if ((i_rsE != 5'd0) && i_RegwriteM && (i_rsE == i_WriteregM))
      o_ForwardAE = 2'b10;
    else if ((i_rsE != 5'd0) && i_RegwriteW && (i_rsE == i_WriteregW))
      o_ForwardAE = 2'b01;
  end

  always_comb begin
    o_ForwardBE = 2'b00;
    if ((i_rtE != 5'd0) && i_RegwriteM && (i_rtE == i_WriteregM))
      o_ForwardBE = 2'b10;
    else if ((i_rtE != 5'd0) && i_RegwriteW && (i_rtE == i_WriteregW))
      o_ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_memstall) begin
            r_state    <= MWAIT;
            r_wait_cnt <= WCW'(1);
          end
        end
        MWAIT: begin
          if (!w_memstall) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
            r_state   <= ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase
    end
  end

  assign w_lw_count  = !w_in_err && !w_memstall && w_hazard;
  assign w_mem_count = !w_in_err && w_memstall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lw_cnt  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if (w_lw_count && (r_lw_cnt != {CNT_W{1'b1}}))
        r_lw_cnt <= r_lw_cnt + CNT_W'(1);
      if (w_mem_count && (r_mem_cnt != {CNT_W{1'b1}}))
        r_mem_cnt <= r_mem_cnt + CNT_W'(1);
    end
  end

  assign o_mem_err       = r_mem_err;
  assign o_lw_stall_cnt  = r_lw_cnt;
  assign o_mem_stall_cnt = r_mem_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per cycle and compares outputs and counters.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, WriteregE, WriteregM, WriteregW;
  logic BranchD, PCSrcD, RegwriteE, MemtoregE, RegwriteM, MemtoregM, MemwriteM;
  logic dmem_ready, RegwriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic ForwardAD, ForwardBD, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] lw_stall_cnt, mem_stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_rsD(rsD), .i_rtD(rtD), .i_rsE(rsE), .i_rtE(rtE),
    .i_BranchD(BranchD), .i_PCSrcD(PCSrcD),
    .i_WriteregE(WriteregE), .i_RegwriteE(RegwriteE), .i_MemtoregE(MemtoregE),
    .i_WriteregM(WriteregM), .i_RegwriteM(RegwriteM), .i_MemtoregM(MemtoregM),
    .i_MemwriteM(MemwriteM), .i_dmem_ready(dmem_ready),
    .i_WriteregW(WriteregW), .i_RegwriteW(RegwriteW),
    .o_StallF(StallF), .o_StallD(StallD), .o_StallE(StallE), .o_StallM(StallM),
    .o_FlushD(FlushD), .o_FlushE(FlushE), .o_FlushW(FlushW),
    .o_ForwardAD(ForwardAD), .o_ForwardBD(ForwardBD),
    .o_ForwardAE(ForwardAE), .o_ForwardBE(ForwardBE),
    .o_mem_err(mem_err), .o_lw_stall_cnt(lw_stall_cnt), .o_mem_stall_cnt(mem_stall_cnt)
  );

  typedef struct {
    string       nm;
    logic [13:0] v;
    int          lw;
    int          mem;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Vector layout: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, AD,BD, AE, BE, mem_err}
  function automatic logic [13:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fd, input logic [1:0] ae,
                                     input logic [1:0] be, input logic err);
    return {st, fl, fd, ae, be, err};
  endfunction

  task automatic expect_out(input string nm, input logic [13:0] v, input int lw, input int mem);
    exp_t e;
    e.nm = nm; e.v = v; e.lw = lw; e.mem = mem;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; WriteregE = 0; WriteregM = 0; WriteregW = 0;
    BranchD = 0; PCSrcD = 0; RegwriteE = 0; MemtoregE = 0; RegwriteM = 0;
    MemtoregM = 0; MemwriteM = 0; dmem_ready = 1; RegwriteW = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [13:0] act;
      mon_e = sb.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAD, ForwardBD, ForwardAE, ForwardBE, mem_err};
      checks++;
      if (act !== mon_e.v) begin
        errors++;
        $display("FAIL %s outputs got %b want %b", mon_e.nm, act, mon_e.v);
      end
      checks++;
      if (int'(lw_stall_cnt) != mon_e.lw || int'(mem_stall_cnt) != mon_e.mem) begin
        errors++;
        $display("FAIL %s counters got lw=%0d mem=%0d want lw=%0d mem=%0d",
                 mon_e.nm, lw_stall_cnt, mem_stall_cnt, mon_e.lw, mon_e.mem);
      end
      $display("txn %-12s out=%b lw=%0d mem=%0d", mon_e.nm, act, lw_stall_cnt, mem_stall_cnt);
    end
  end

  localparam logic [3:0] S0 = 4'b0000, SH = 4'b1100, SA = 4'b1111;
  localparam logic [2:0] F0 = 3'b000, FD = 3'b100, FE = 3'b010, FW = 3'b001;

  initial begin
    clear_in();
    rst = 1'b1;
    cyc(); expect_out("reset", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);
    cyc(); rst = 1'b0; expect_out("idle", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);

    // Forwarding priority and register 0
    cyc(); clear_in(); RegwriteM = 1; WriteregM = 3; rsE = 3; RegwriteW = 1; WriteregW = 3;
    expect_out("fwdAE_M", ev(S0, F0, 2'b00, 2'b10, 2'b00, 1'b0), 0, 0);
    cyc(); RegwriteM = 0;
    expect_out("fwdAE_W", ev(S0, F0, 2'b00, 2'b01, 2'b00, 1'b0), 0, 0);
    cyc(); rsE = 0;
    expect_out("fwdAE_r0", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);
    cyc(); clear_in(); RegwriteM = 1; WriteregM = 7; RegwriteW = 1; WriteregW = 7;
    rtE = 7; rsD = 7; rtD = 7;
    expect_out("fwdBE_D", ev(S0, F0, 2'b11, 2'b00, 2'b10, 1'b0), 0, 0);
    cyc(); clear_in(); RegwriteM = 1; RegwriteW = 1;
    expect_out("fwd_reg0", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);
    cyc(); clear_in(); RegwriteW = 1; WriteregW = 9; rtE = 9;
    expect_out("fwdBE_W", ev(S0, F0, 2'b00, 2'b00, 2'b01, 1'b0), 0, 0);

    // Load-use stall
    cyc(); clear_in(); MemtoregE = 1; rtE = 5; rsD = 5;
    expect_out("lwstall", ev(SH, FE, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);
    cyc(); clear_in();
    expect_out("lw_after", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 1, 0);

    // Branch stall beats a taken branch; then taken branch flushes D
    cyc(); BranchD = 1; rsD = 4; RegwriteE = 1; WriteregE = 4; PCSrcD = 1;
    expect_out("brstall_E", ev(SH, FE, 2'b00, 2'b00, 2'b00, 1'b0), 1, 0);
    cyc(); RegwriteE = 0;
    expect_out("br_taken", ev(S0, FD, 2'b00, 2'b00, 2'b00, 1'b0), 2, 0);
    cyc(); clear_in(); BranchD = 1; rtD = 6; MemtoregM = 1; WriteregM = 6;
    expect_out("brstall_M", ev(SH, FE, 2'b00, 2'b00, 2'b00, 1'b0), 2, 0);
    cyc(); clear_in(); BranchD = 1; RegwriteE = 1; MemtoregM = 1;
    expect_out("br_reg0", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 3, 0);

    // Store waits 3 cycles with a concurrent load-use hazard
    for (int i = 0; i < 3; i++) begin
      cyc(); clear_in(); MemwriteM = 1; dmem_ready = 0; MemtoregE = 1; rtE = 5; rsD = 5;
      expect_out("st_wait", ev(SA, FW, 2'b00, 2'b00, 2'b00, 1'b0), 3, i);
    end
    cyc(); clear_in(); MemwriteM = 1; dmem_ready = 1;
    expect_out("st_ready", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 3, 3);
    cyc(); clear_in(); PCSrcD = 1;
    expect_out("st_run", ev(S0, FD, 2'b00, 2'b00, 2'b00, 1'b0), 3, 3);

    // Load timeout into the error trap
    for (int i = 0; i < TO; i++) begin
      cyc(); clear_in(); MemtoregM = 1; dmem_ready = 0;
      expect_out("ld_wait", ev(SA, FW, 2'b00, 2'b00, 2'b00, 1'b0), 3, 3 + i);
    end
    cyc(); expect_out("err_entry", ev(SA, FW, 2'b00, 2'b00, 2'b00, 1'b1), 3, 7);
    cyc(); clear_in(); MemtoregE = 1; rtE = 5; rsD = 5; PCSrcD = 1;
    expect_out("err_hold", ev(SA, FW, 2'b00, 2'b00, 2'b00, 1'b1), 3, 7);
    cyc(); expect_out("err_nocnt", ev(SA, FW, 2'b00, 2'b00, 2'b00, 1'b1), 3, 7);
    cyc(); clear_in(); rst = 1'b1;
    expect_out("err_rst", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);
    cyc(); rst = 1'b0;
    expect_out("post_rst", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 0, 0);

    // Repeated load-use stall saturates the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      cyc(); clear_in(); MemtoregE = 1; rtE = 5; rtD = 5;
      expect_out("lw_sat", ev(SH, FE, 2'b00, 2'b00, 2'b00, 1'b0), (i < 15) ? i : 15, 0);
    end
    cyc(); clear_in();
    expect_out("sat_hold", ev(S0, F0, 2'b00, 2'b00, 2'b00, 1'b0), 15, 0);

    cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
